ula_sequenciador: RTL
=====================

Name: ula_sequenciador

Overview:
Upstream control stage for the 4-bit ALU: owns a 4-entry x 4-bit register bank and a flag register {C,V,N,Z}. It accepts one instruction at a time over a valid/ready handshake and drives the ALU's A, B and seletor inputs. It then captures resultado and the flags, and writes the result back to the bank. Multicycle, one instruction in flight, fixed 3-cycle latency.

Parameters:
WIDTH, 4, data width of registers and ALU operands (must match the ALU)
REG_BITS, 2, register index width (2**REG_BITS registers)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction
instr_load  input  1  1 = load immediate into rd (no ALU op)
instr_op  input  4  ALU seletor code
instr_rd  input  REG_BITS  destination register
instr_rs1  input  REG_BITS  source for ALU A
instr_rs2  input  REG_BITS  source for ALU B
instr_imm  input  WIDTH  immediate for load
alu_A  output  WIDTH  to ALU A
alu_B  output  WIDTH  to ALU B
alu_sel  output  4  to ALU seletor
alu_resultado  input  WIDTH  from ALU
alu_C, alu_V, alu_N, alu_Z  input  1 each  ALU flags
flags  output  4  registered {C,V,N,Z}
done  output  1  one-cycle completion pulse
rd_sel  input  REG_BITS  debug read index
rd_data  output  WIDTH  combinational read of R[rd_sel]

Behaviour:
- Reset (rst=1 at a clock edge): all registers 0, flags 0000, state IDLE, done 0, alu_A/alu_B/alu_sel 0. instr_ready is 1 in the first cycle after reset.
- States: IDLE, EXEC, WB. instr_ready = (state==IDLE).
- IDLE: on instr_valid & instr_ready at an edge, latch load, op, rd and imm. Also latch the operand values R[rs1] and R[rs2], not their indices. Go to EXEC. Without valid, stay in IDLE.
- EXEC (1 cycle): drive alu_A/alu_B/alu_sel from the latched operands and op. At the edge ending EXEC, capture alu_resultado and the four flags, then go to WB. For a load, the ALU outputs are don't-care; the ALU is still driven with the latched values.
- WB (1 cycle): at the edge ending WB, write R[rd] and go to IDLE.
  - ALU op: R[rd] = captured result; flags = captured {C,V,N,Z}.
  - Load: R[rd] = imm; flags unchanged.
- done: registered; high for exactly the cycle after the WB edge (the first IDLE cycle), otherwise 0.
- Latency: accept at edge k; write and done at edge k+2. Throughput is one instruction per 3 cycles. A new instruction may be accepted in the cycle done is high.
- Outside IDLE, alu_A/alu_B/alu_sel hold their last values (no glitching to 0).
- Hazards: operands are latched at accept, so rd==rs1/rs2 is safe. rs1==rs2 is allowed.
- Instruction inputs are ignored while instr_ready=0.
- Undefined ALU codes (1100-1111): no special case. Whatever the ALU returns (0000, Z=1, C=V=0) is written.
- rd_data reflects a write from the cycle after the WB edge.
- rst mid-EXEC/WB: abort, no write, no done, full reset values.

Decomposition:
- Shared package holds:
  - opcode constants OP_AND=0000, OP_OR=0001, OP_NOT=0010, OP_NAND=0011, OP_ADD=0100, OP_SUB=0101, OP_SHL1=0110, OP_SHR1=0111, OP_SHL=1000, OP_SHR=1001, OP_XOR=1010, OP_NOR=1011
  - state encoding IDLE/EXEC/WB
  - flag bit indices FLAG_C=3, FLAG_V=2, FLAG_N=1, FLAG_Z=0
- One sub-module: banco_registradores (2**REG_BITS x WIDTH, synchronous reset, one write port, three combinational read ports for rs1, rs2 and rd_sel).

Test Plan:
1. Reset: rst high 2 cycles, then low -> rd_data=0000 for rd_sel 0..3, flags=0000, instr_ready=1, done=0.
2. LOAD R0=0111, LOAD R1=0001, then ADD(0100) rd=R2 rs1=R0 rs2=R1 -> during EXEC alu_A=0111, alu_B=0001, alu_sel=0100. Then R2=1000, flags C=0 V=1 N=1 Z=0, done high 3 cycles after accept. The LOADs leave flags at 0000.
3. SUB(0101) rd=R3 rs1=R0 rs2=R0 (R0=0111) -> R3=0000, flags C=1 V=0 N=0 Z=1.
4. Hazard: R0=0101, ADD rd=R0 rs1=R0 rs2=R0 -> R0=1010, flags C=0 V=1 N=1 Z=0. A following LOAD R1=1111 keeps flags unchanged.
5. Back-to-back: instr_valid held high with a new instruction each accept -> accepts exactly every 3 cycles. Input changes during EXEC/WB are ignored; the second accept coincides with the first done.
6. Reset mid-op: accept SUB rd=R2, assert rst during EXEC -> next cycle IDLE, done=0, all registers and flags 0, instr_ready=1.

Source files
------------

// File: rtl/ula_sequenciador_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, flag bit positions.
package ula_sequenciador_pkg;

    // ALU seletor codes; 1100-1111 are undefined and get no special handling.
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SHL1 = 4'b0110;
    localparam logic [3:0] OP_SHR1 = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;

    // Sequencer states: accept, drive ALU, write back.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Bit positions inside the {C,V,N,Z} flag vector.
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/ula_sequenciador_if.sv
// Instruction handshake and ALU operand/result bus of the sequencer.
// master = instruction source that also hosts the ALU; slave = the sequencer.
interface ula_sequenciador_if #(
    parameter int WIDTH    = 4,
    parameter int REG_BITS = 2
);
    logic                instr_valid;
    logic                instr_ready;
    logic                instr_load;
    logic [3:0]          instr_op;
    logic [REG_BITS-1:0] instr_rd;
    logic [REG_BITS-1:0] instr_rs1;
    logic [REG_BITS-1:0] instr_rs2;
    logic [WIDTH-1:0]    instr_imm;

    logic [WIDTH-1:0]    alu_A;
    logic [WIDTH-1:0]    alu_B;
    logic [3:0]          alu_sel;
    logic [WIDTH-1:0]    alu_resultado;
    logic                alu_C;
    logic                alu_V;
    logic                alu_N;
    logic                alu_Z;

    modport master (
        output instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  instr_ready,
        input  alu_A, alu_B, alu_sel,
        output alu_resultado, alu_C, alu_V, alu_N, alu_Z
    );

    modport slave (
        input  instr_valid, instr_load, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output instr_ready,
        output alu_A, alu_B, alu_sel,
        input  alu_resultado, alu_C, alu_V, alu_N, alu_Z
    );
endinterface

// File: rtl/ula_sequenciador_banco_registradores.sv
// Register bank: 2**REG_BITS x WIDTH, one synchronous write port, three combinational reads.
module banco_registradores #(
    parameter int WIDTH    = 4,
    parameter int REG_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [REG_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [REG_BITS-1:0] raddr_a,
    output logic [WIDTH-1:0]    rdata_a,
    input  logic [REG_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]    rdata_b,
    input  logic [REG_BITS-1:0] raddr_c,
    output logic [WIDTH-1:0]    rdata_c
);
    logic [WIDTH-1:0] regs [2**REG_BITS];

    // Clear all entries on reset, otherwise write the addressed entry.
    // NOTE: the bank is tiny and architecturally visible, so it is reset like
    // ordinary flops; larger memories would normally be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_BITS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];
endmodule

// File: rtl/ula_sequenciador.sv
// ALU sequencer: accepts one instruction, drives the ALU, captures result/flags,
// writes back. Fixed 3-cycle IDLE -> EXEC -> WB loop.
module ula_sequenciador
    import ula_sequenciador_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int REG_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    ula_sequenciador_if.slave   bus,
    output logic [3:0]          flags,
    output logic                done,
    input  logic [REG_BITS-1:0] rd_sel,
    output logic [WIDTH-1:0]    rd_data
);
    state_t              state;
    logic                load_q;
    logic [REG_BITS-1:0] rd_q;
    logic [WIDTH-1:0]    imm_q;
    logic [WIDTH-1:0]    res_q;
    logic [3:0]          cap_flags_q;

    logic [WIDTH-1:0]    rs1_data;
    logic [WIDTH-1:0]    rs2_data;
    logic                wr_en;
    logic [WIDTH-1:0]    wr_data;

    assign bus.instr_ready = (state == IDLE);
    assign wr_en           = (state == WB);
    assign wr_data         = load_q ? imm_q : res_q;

    banco_registradores #(
        .WIDTH    (WIDTH),
        .REG_BITS (REG_BITS)
    ) u_banco (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .waddr   (rd_q),
        .wdata   (wr_data),
        .raddr_a (bus.instr_rs1),
        .rdata_a (rs1_data),
        .raddr_b (bus.instr_rs2),
        .rdata_b (rs2_data),
        .raddr_c (rd_sel),
        .rdata_c (rd_data)
    );

    // Sequencer FSM with registered ALU drive, captured result and done pulse.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, e.g. operands latched at accept ignore the
    // same-edge write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            load_q      <= 1'b0;
            rd_q        <= '0;
            imm_q       <= '0;
            res_q       <= '0;
            cap_flags_q <= '0;
            flags       <= '0;
            done        <= 1'b0;
            bus.alu_A   <= '0;
            bus.alu_B   <= '0;
            bus.alu_sel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.instr_valid) begin
                        // Operand values, not indices, are latched: rd==rs is hazard-free.
                        load_q      <= bus.instr_load;
                        rd_q        <= bus.instr_rd;
                        imm_q       <= bus.instr_imm;
                        bus.alu_A   <= rs1_data;
                        bus.alu_B   <= rs2_data;
                        bus.alu_sel <= bus.instr_op;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    res_q               <= bus.alu_resultado;
                    cap_flags_q[FLAG_C] <= bus.alu_C;
                    cap_flags_q[FLAG_V] <= bus.alu_V;
                    cap_flags_q[FLAG_N] <= bus.alu_N;
                    cap_flags_q[FLAG_Z] <= bus.alu_Z;
                    state               <= WB;
                end
                WB: begin
                    // Loads leave the flag register untouched.
                    if (!load_q) flags <= cap_flags_q;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
